pc_fetch_unit: RTL



---
 rtl/riscv_core_pkg.sv | 22 ++
 rtl/next_pc_sel.sv | 30 +++
 rtl/pc_fetch_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/riscv_core_pkg.sv
// Shared types and encodings for the single-cycle core front end.
package riscv_core_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned PC_SRC_W     = 2;
    localparam int unsigned PERF_W       = 64;

    localparam logic [PC_SRC_W-1:0] PC_SEQ    = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_BRANCH = 2'b01;
    localparam logic [PC_SRC_W-1:0] PC_JUMP   = 2'b10;
    localparam logic [PC_SRC_W-1:0] PC_RSVD   = 2'b11;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        TRAP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux from pc_src and execute results; flags word-misaligned targets.
module next_pc_sel
    import riscv_core_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [PC_SRC_W-1:0] pc_src_i,
    input  logic                branch_taken_i,
    input  logic [XLEN-1:0]     branch_target_i,
    input  logic [XLEN-1:0]     jump_target_i,
    input  logic [XLEN-1:0]     instr_pc_plus4_i,
    output logic [XLEN-1:0]     next_pc_c_o,
    output logic                misaligned_c_o
);

    always_comb begin
        next_pc_c_o = instr_pc_plus4_i;
        case (pc_src_i)
            PC_SEQ:    next_pc_c_o = instr_pc_plus4_i;
            PC_BRANCH: if (branch_taken_i) next_pc_c_o = branch_target_i;
            // JALR semantics: target LSB is cleared before use
            PC_JUMP:   next_pc_c_o = jump_target_i & ~XLEN'(1);
            PC_RSVD:   next_pc_c_o = instr_pc_plus4_i;
            default:   next_pc_c_o = instr_pc_plus4_i;
        endcase
    end

    assign misaligned_c_o = next_pc_c_o[1];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and instruction fetch front end with sticky misaligned-target trap.
// Optional PC_FETCH_PERF_COUNTERS_EN adds cycle_count and instret_count outputs.
module pc_fetch_unit
    import riscv_core_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instr,
    output logic [XLEN-1:0]     instr_pc,
    output logic [XLEN-1:0]     instr_pc_plus4,
    output logic                instr_valid,
    input  logic                instr_ack,
    input  logic [PC_SRC_W-1:0] pc_src,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     branch_target,
    input  logic [XLEN-1:0]     jump_target,
    input  logic                stall,
    output logic                trap,
    output logic [XLEN-1:0]     trap_pc
`ifdef PC_FETCH_PERF_COUNTERS_EN
    ,
    output logic [PERF_W-1:0]   cycle_count,
    output logic [PERF_W-1:0]   instret_count
`endif
);

    fetch_state_t        state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                req_q, req_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]     instr_pc_q, instr_pc_d;
    logic [XLEN-1:0]     instr_pc_plus4_q, instr_pc_plus4_d;
    logic                valid_q, valid_d;
    logic                trap_q, trap_d;
    logic [XLEN-1:0]     trap_pc_q, trap_pc_d;

    logic [XLEN-1:0]     next_pc_c;
    logic                misaligned_c;
    logic                ack_accept_c;

    next_pc_sel #(
        .XLEN (XLEN)
    ) u_next_pc_sel (
        .pc_src_i         (pc_src),
        .branch_taken_i   (branch_taken),
        .branch_target_i  (branch_target),
        .jump_target_i    (jump_target),
        .instr_pc_plus4_i (instr_pc_plus4_q),
        .next_pc_c_o      (next_pc_c),
        .misaligned_c_o   (misaligned_c)
    );

    assign ack_accept_c = (state_q == HOLD) && instr_ack && !stall;

    // Next-state and registered-output computation
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        req_d            = req_q;
        instr_d          = instr_q;
        instr_pc_d       = instr_pc_q;
        instr_pc_plus4_d = instr_pc_plus4_q;
        valid_d          = valid_q;
        trap_d           = trap_q;
        trap_pc_d        = trap_pc_q;

        case (state_q)
            FETCH: begin
                valid_d = 1'b0;
                if (req_q) begin
                    // An outstanding request is held stable until the memory accepts it
                    if (imem_ready) begin
                        instr_d          = imem_rdata;
                        instr_pc_d       = pc_q;
                        instr_pc_plus4_d = pc_q + XLEN'(4);
                        valid_d          = 1'b1;
                        req_d            = 1'b0;
                        state_d          = HOLD;
                    end
                end else begin
                    req_d = !stall;
                end
            end
            HOLD: begin
                if (ack_accept_c) begin
                    valid_d = 1'b0;
                    if (misaligned_c) begin
                        trap_d    = 1'b1;
                        trap_pc_d = instr_pc_q;
                        req_d     = 1'b0;
                        state_d   = TRAP;
                    end else begin
                        pc_d    = next_pc_c;
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            TRAP: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                trap_d  = 1'b1;
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                trap_d  = 1'b1;
                state_d = TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= FETCH;
            pc_q             <= RESET_PC;
            req_q            <= 1'b0;
            instr_q          <= NOP_INSTR;
            instr_pc_q       <= RESET_PC;
            instr_pc_plus4_q <= RESET_PC + XLEN'(4);
            valid_q          <= 1'b0;
            trap_q           <= 1'b0;
            trap_pc_q        <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            req_q            <= req_d;
            instr_q          <= instr_d;
            instr_pc_q       <= instr_pc_d;
            instr_pc_plus4_q <= instr_pc_plus4_d;
            valid_q          <= valid_d;
            trap_q           <= trap_d;
            trap_pc_q        <= trap_pc_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = pc_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_plus4_q;
    assign instr_valid    = valid_q;
    assign trap           = trap_q;
    assign trap_pc        = trap_pc_q;

`ifdef PC_FETCH_PERF_COUNTERS_EN
    logic [PERF_W-1:0] cycle_q, cycle_d;
    logic [PERF_W-1:0] instret_q, instret_d;
    logic              retire_c;

    // Trapping acks never retire
    assign retire_c  = ack_accept_c && !misaligned_c;
    assign cycle_d   = cycle_q + PERF_W'(1);
    assign instret_d = instret_q + PERF_W'(retire_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`endif

endmodule
